// File: rtl/xoodyak_pkg.sv
// Shared types, constants and helpers for the single-block Xoodyak keyed AEAD engine.
// Xoodoo state layout: lane x+4y occupies bits [32*(x+4y)+31 : 32*(x+4y)].
package xoodyak_pkg;

  localparam int NROUNDS = 12;
  localparam int STATE_W = 384;
  localparam int TEXT_W  = 192;
  localparam int BLK_W   = 128;

  localparam logic [7:0] DOM_KEY     = 8'h02;
  localparam logic [7:0] DOM_ABSORB  = 8'h03;
  localparam logic [7:0] DOM_CRYPT   = 8'h80;
  localparam logic [7:0] DOM_SQUEEZE = 8'h40;

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic {ST_IDLE, ST_PERM} fsm_t;

  function automatic int lane_lsb(input int x, input int y);
    return 32 * (x + 4 * y);
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] round_const(input logic [3:0] r);
    case (r)
      4'd0:    return 32'h058;
      4'd1:    return 32'h038;
      4'd2:    return 32'h3C0;
      4'd3:    return 32'h0D0;
      4'd4:    return 32'h120;
      4'd5:    return 32'h014;
      4'd6:    return 32'h060;
      4'd7:    return 32'h02C;
      4'd8:    return 32'h380;
      4'd9:    return 32'h0F0;
      4'd10:   return 32'h1A0;
      4'd11:   return 32'h012;
      default: return 32'h000;
    endcase
  endfunction

  // Key block: K, empty-id length byte (0x00), padding 0x01, key domain in the last byte.
  function automatic state_t key_block(input logic [BLK_W-1:0] k);
    state_t s;
    s = '0;
    s[BLK_W-1:0]      = k;
    s[143:136]        = 8'h01;
    s[STATE_W-1 -: 8] = DOM_KEY;
    return s;
  endfunction

  function automatic state_t absorb_block(input logic [BLK_W-1:0] d, input logic [7:0] dom);
    state_t s;
    s = '0;
    s[BLK_W-1:0]      = d;
    s[135:128]        = 8'h01;
    s[STATE_W-1 -: 8] = dom;
    return s;
  endfunction

  function automatic state_t squeeze_block(input logic [TEXT_W-1:0] p);
    state_t s;
    s = '0;
    s[TEXT_W-1:0]     = p;
    s[199:192]        = 8'h01;
    s[STATE_W-1 -: 8] = DOM_SQUEEZE;
    return s;
  endfunction

endpackage

// File: rtl/xoodyak_aead_core_if.sv
// Request/response bundle of the AEAD core; master drives an operation, slave is the core.
interface xoodyak_aead_core_if;
  import xoodyak_pkg::*;

  logic              start;
  logic [TEXT_W-1:0] textin;
  logic [BLK_W-1:0]  nonce;
  logic [BLK_W-1:0]  assodata;
  logic [BLK_W-1:0]  key;
  logic [BLK_W-1:0]  verification_data;
  logic              opmode;
  logic [BLK_W-1:0]  authdata;
  logic [TEXT_W-1:0] textout;
  logic              encdone;
  logic              sqzdone;
  logic              verify;

  modport master (
    output start, textin, nonce, assodata, key, verification_data, opmode,
    input  authdata, textout, encdone, sqzdone, verify
  );

  modport slave (
    input  start, textin, nonce, assodata, key, verification_data, opmode,
    output authdata, textout, encdone, sqzdone, verify
  );

endinterface

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round: theta, rho_west, iota, chi, rho_east.
module xoodoo_round
  import xoodyak_pkg::*;
(
  input  state_t      state_in,
  input  logic [31:0] rc,
  output state_t      state_out
);

  logic [31:0] a   [3][4];
  logic [31:0] col [4];
  logic [31:0] eff [4];
  logic [31:0] th  [3][4];
  logic [31:0] w   [3][4];
  logic [31:0] c   [3][4];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      for (gj = 0; gj < 3; gj++) begin : g_plane
        assign a[gj][gi]  = state_in[lane_lsb(gi, gj) +: 32];
        assign th[gj][gi] = a[gj][gi] ^ eff[gi];
        assign c[gj][gi]  = w[gj][gi] ^ (~w[(gj+1)%3][gi] & w[(gj+2)%3][gi]);
      end

      assign col[gi] = a[0][gi] ^ a[1][gi] ^ a[2][gi];
      // Column effect pulls from column x-1, hence the (gi+3)%4 index.
      assign eff[gi] = rotl32(col[(gi+3)%4], 5) ^ rotl32(col[(gi+3)%4], 14);

      assign w[0][gi] = th[0][gi] ^ ((gi == 0) ? rc : 32'h0);
      assign w[1][gi] = th[1][(gi+3)%4];
      assign w[2][gi] = rotl32(th[2][gi], 11);

      assign state_out[lane_lsb(gi, 0) +: 32] = c[0][gi];
      assign state_out[lane_lsb(gi, 1) +: 32] = rotl32(c[1][gi], 1);
      assign state_out[lane_lsb(gi, 2) +: 32] = rotl32(c[2][(gi+2)%4], 8);
    end
  endgenerate

endmodule

// File: rtl/xoodyak_aead_core.sv
// Single-block Xoodyak keyed AEAD: four 12-round permutations, one round per cycle,
// with nonce, AD, text and squeeze injections folded into each permutation's last round.
module xoodyak_aead_core
  import xoodyak_pkg::*;
(
  input logic                 eph1,
  input logic                 reset,
  xoodyak_aead_core_if.slave  bus
);

  fsm_t              fsm_reg, fsm_next;
  logic [1:0]        phase_reg, phase_next;
  logic [3:0]        round_reg, round_next;
  state_t            state_reg, state_next, round_out;
  logic [TEXT_W-1:0] text_reg, text_next, textout_reg, textout_next;
  logic [BLK_W-1:0]  nonce_reg, nonce_next, ad_reg, ad_next;
  logic [BLK_W-1:0]  vdata_reg, vdata_next, auth_reg, auth_next;
  logic              mode_reg, mode_next;
  logic              encdone_reg, encdone_next, sqzdone_reg, sqzdone_next;
  logic              verify_reg, verify_next;
  logic [31:0]       rc_cur;
  logic [TEXT_W-1:0] y_blk, p_blk;
  logic              last_round;

  assign rc_cur = round_const(round_reg);

  xoodoo_round u_round (
    .state_in  (state_reg),
    .rc        (rc_cur),
    .state_out (round_out)
  );

  always_comb begin
    fsm_next     = fsm_reg;
    phase_next   = phase_reg;
    round_next   = round_reg;
    state_next   = state_reg;
    text_next    = text_reg;
    textout_next = textout_reg;
    nonce_next   = nonce_reg;
    ad_next      = ad_reg;
    vdata_next   = vdata_reg;
    auth_next    = auth_reg;
    mode_next    = mode_reg;
    verify_next  = verify_reg;
    encdone_next = 1'b0;
    sqzdone_next = 1'b0;
    last_round   = (round_reg == 4'(NROUNDS - 1));
    y_blk        = round_out[TEXT_W-1:0];
    // Decrypt absorbs the recovered plaintext, encrypt absorbs its own input.
    p_blk        = mode_reg ? (text_reg ^ y_blk) : text_reg;

    case (fsm_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = key_block(bus.key);
          text_next  = bus.textin;
          nonce_next = bus.nonce;
          ad_next    = bus.assodata;
          vdata_next = bus.verification_data;
          mode_next  = bus.opmode;
          phase_next = 2'd0;
          round_next = 4'd0;
          fsm_next   = ST_PERM;
        end
      end
      ST_PERM: begin
        state_next = round_out;
        round_next = round_reg + 4'd1;
        if (last_round) begin
          round_next = 4'd0;
          phase_next = phase_reg + 2'd1;
          case (phase_reg)
            2'd0: state_next = round_out ^ absorb_block(nonce_reg, DOM_ABSORB);
            2'd1: state_next = round_out ^ absorb_block(ad_reg, DOM_ABSORB ^ DOM_CRYPT);
            2'd2: begin
              textout_next = text_reg ^ y_blk;
              state_next   = round_out ^ squeeze_block(p_blk);
              encdone_next = 1'b1;
            end
            default: begin
              auth_next    = round_out[BLK_W-1:0];
              verify_next  = (round_out[BLK_W-1:0] == vdata_reg);
              sqzdone_next = 1'b1;
              fsm_next     = ST_IDLE;
            end
          endcase
        end
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge eph1 or negedge reset) begin
    if (!reset) begin
      fsm_reg     <= ST_IDLE;
      phase_reg   <= '0;
      round_reg   <= '0;
      state_reg   <= '0;
      text_reg    <= '0;
      textout_reg <= '0;
      nonce_reg   <= '0;
      ad_reg      <= '0;
      vdata_reg   <= '0;
      auth_reg    <= '0;
      mode_reg    <= 1'b0;
      encdone_reg <= 1'b0;
      sqzdone_reg <= 1'b0;
      verify_reg  <= 1'b0;
    end else begin
      fsm_reg     <= fsm_next;
      phase_reg   <= phase_next;
      round_reg   <= round_next;
      state_reg   <= state_next;
      text_reg    <= text_next;
      textout_reg <= textout_next;
      nonce_reg   <= nonce_next;
      ad_reg      <= ad_next;
      vdata_reg   <= vdata_next;
      auth_reg    <= auth_next;
      mode_reg    <= mode_next;
      encdone_reg <= encdone_next;
      sqzdone_reg <= sqzdone_next;
      verify_reg  <= verify_next;
    end
  end

  assign bus.textout  = textout_reg;
  assign bus.authdata = auth_reg;
  assign bus.encdone  = encdone_reg;
  assign bus.sqzdone  = sqzdone_reg;
  assign bus.verify   = verify_reg;

endmodule

// File: tb/tb_xoodyak_aead_core.sv
// Scoreboard bench: a Cyclist-level Xoodyak model predicts each operation, a negedge
// monitor pops and compares whenever an instance pulses encdone or sqzdone.
module tb_xoodyak_aead_core;
  import xoodyak_pkg::*;

  localparam logic [127:0] K  = 128'h38393a3b3c3d3e3f3031323334353637;
  localparam logic [127:0] N  = 128'h494a4b4c4d4e4f504142434445464748;
  localparam logic [127:0] AD = 128'h696a6b6c6d6e6f706162636465666768;
  localparam logic [191:0] PT = 192'h4d4e4f5051525354555657584142434445464748494a4b4c;

  typedef struct {
    logic [191:0] text;
    logic [127:0] tag;
    logic         verify;
    int           e0;
  } exp_t;

  logic eph1 = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t enc_q[$];
  exp_t dec_q[$];

  logic [31:0] rct [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                            32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

  always #5 eph1 = ~eph1;
  always @(posedge eph1) cyc <= cyc + 1;

  xoodyak_aead_core_if enc_if();
  xoodyak_aead_core_if dec_if();

  xoodyak_aead_core u_enc (.eph1(eph1), .reset(reset), .bus(enc_if.slave));
  xoodyak_aead_core u_dec (.eph1(eph1), .reset(reset), .bus(dec_if.slave));

  logic [383:0] rt_in, rt_out;
  logic [31:0]  rt_rc;
  xoodoo_round u_round (.state_in(rt_in), .rc(rt_rc), .state_out(rt_out));

  // ---------------- reference model (Cyclist Up/Down on a 48-byte state) ----------------
  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [383:0] m_perm(input logic [383:0] s);
    logic [31:0] la [12];
    logic [31:0] lb [12];
    logic [31:0] pc [4];
    logic [31:0] ec [4];
    logic [31:0] tp [4];
    for (int i = 0; i < 12; i++) la[i] = s[32*i +: 32];
    for (int r = 0; r < 12; r++) begin
      for (int x = 0; x < 4; x++) pc[x] = la[x] ^ la[x+4] ^ la[x+8];
      for (int x = 0; x < 4; x++) ec[x] = rol(pc[(x+3)%4], 5) ^ rol(pc[(x+3)%4], 14);
      for (int i = 0; i < 12; i++) la[i] = la[i] ^ ec[i%4];
      for (int x = 0; x < 4; x++) tp[x] = la[4+x];
      for (int x = 0; x < 4; x++) la[4+x] = tp[(x+3)%4];
      for (int x = 0; x < 4; x++) la[8+x] = rol(la[8+x], 11);
      la[0] = la[0] ^ rct[r];
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 3; y++)
          lb[x+4*y] = ~la[x+4*((y+1)%3)] & la[x+4*((y+2)%3)];
      for (int i = 0; i < 12; i++) la[i] = la[i] ^ lb[i];
      for (int x = 0; x < 4; x++) la[4+x] = rol(la[4+x], 1);
      for (int x = 0; x < 4; x++) tp[x] = la[8+x];
      for (int x = 0; x < 4; x++) la[8+x] = rol(tp[(x+2)%4], 8);
    end
    for (int i = 0; i < 12; i++) s[32*i +: 32] = la[i];
    return s;
  endfunction

  function automatic logic [383:0] m_down(input logic [383:0] s, input logic [191:0] xb,
                                          input int len, input logic [7:0] cd);
    for (int i = 0; i < len; i++) s[8*i +: 8] = s[8*i +: 8] ^ xb[8*i +: 8];
    s[8*len +: 8] = s[8*len +: 8] ^ 8'h01;
    s[376 +: 8]   = s[376 +: 8] ^ cd;
    return s;
  endfunction

  function automatic logic [383:0] m_up(input logic [383:0] s, input logic [7:0] cu);
    s[376 +: 8] = s[376 +: 8] ^ cu;
    return m_perm(s);
  endfunction

  task automatic m_aead(input logic [127:0] k, input logic [127:0] n, input logic [127:0] ad,
                        input logic [191:0] txt, input logic dec,
                        output logic [191:0] out, output logic [127:0] tag);
    logic [383:0] s;
    logic [191:0] p;
    s   = '0;
    s   = m_down(s, {64'h0, k}, 17, 8'h02);
    s   = m_up(s, 8'h00);
    s   = m_down(s, {64'h0, n}, 16, 8'h03);
    s   = m_up(s, 8'h00);
    s   = m_down(s, {64'h0, ad}, 16, 8'h03);
    s   = m_up(s, 8'h80);
    out = txt ^ s[191:0];
    p   = dec ? out : txt;
    s   = m_down(s, p, 24, 8'h00);
    s   = m_up(s, 8'h40);
    tag = s[127:0];
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [383:0] got, input logic [383:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s got=event want=none", nm);
  endtask

  task automatic mon(input bit d, input logic encd, input logic sqzd, input logic [191:0] txo,
                     input logic [127:0] au, input logic vf);
    exp_t  e;
    bit    have;
    string nm;
    nm   = d ? "dec" : "enc";
    have = d ? (dec_q.size() != 0) : (enc_q.size() != 0);
    if (have) e = d ? dec_q[0] : enc_q[0];
    if (encd) begin
      if (!have) fail_now({nm, "_unexpected_encdone"});
      else begin
        chk({nm, "_textout"}, 384'(txo), 384'(e.text));
        chk({nm, "_encdone_latency"}, 384'(cyc), 384'(e.e0 + 36));
      end
    end
    if (sqzd) begin
      if (!have) fail_now({nm, "_unexpected_sqzdone"});
      else begin
        chk({nm, "_authdata"}, 384'(au), 384'(e.tag));
        chk({nm, "_verify"}, 384'(vf), 384'(e.verify));
        chk({nm, "_sqzdone_latency"}, 384'(cyc), 384'(e.e0 + 48));
        if (d) void'(dec_q.pop_front());
        else   void'(enc_q.pop_front());
      end
    end
  endtask

  always @(negedge eph1) begin
    mon(1'b0, enc_if.encdone, enc_if.sqzdone, enc_if.textout, enc_if.authdata, enc_if.verify);
    mon(1'b1, dec_if.encdone, dec_if.sqzdone, dec_if.textout, dec_if.authdata, dec_if.verify);
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [191:0] r192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input bit d, input logic st, input logic [127:0] k, input logic [127:0] n,
                       input logic [127:0] ad, input logic [191:0] txt, input logic m,
                       input logic [127:0] vd);
    if (d) begin
      dec_if.start = st; dec_if.key = k; dec_if.nonce = n; dec_if.assodata = ad;
      dec_if.textin = txt; dec_if.opmode = m; dec_if.verification_data = vd;
    end else begin
      enc_if.start = st; enc_if.key = k; enc_if.nonce = n; enc_if.assodata = ad;
      enc_if.textin = txt; enc_if.opmode = m; enc_if.verification_data = vd;
    end
  endtask

  task automatic scramble(input bit d, input logic st);
    drive(d, st, r128(), r128(), r128(), r192(), 1'($urandom), r128());
  endtask

  task automatic issue(input bit d, input logic [127:0] k, input logic [127:0] n,
                       input logic [127:0] ad, input logic [191:0] txt, input logic m,
                       input logic [127:0] vd, output int e0);
    exp_t e;
    m_aead(k, n, ad, txt, m, e.text, e.tag);
    e.verify = (e.tag == vd);
    @(negedge eph1);
    drive(d, 1'b1, k, n, ad, txt, m, vd);
    e.e0 = cyc + 1;
    e0   = e.e0;
    if (d) dec_q.push_back(e);
    else   enc_q.push_back(e);
    @(negedge eph1);
    scramble(d, 1'b0);
  endtask

  task automatic wait_idle(input bit d, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((d ? dec_q.size() : enc_q.size()) == 0) break;
      @(negedge eph1);
    end
    if ((d ? dec_q.size() : enc_q.size()) != 0) begin
      fail_now(d ? "dec_timeout" : "enc_timeout");
      if (d) dec_q.delete();
      else   enc_q.delete();
    end
  endtask

  initial begin
    logic [191:0] ct;
    logic [127:0] tag;
    int           e0;
    logic         m;
    bit           d;
    logic [127:0] vd;

    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, '0);

    // Standalone round unit iterated 12 times on the zero state.
    rt_in = '0;
    for (int r = 0; r < 12; r++) begin
      rt_rc = rct[r];
      #1;
      rt_in = rt_out;
    end
    chk("xoodoo_perm_zero", rt_in, m_perm('0));

    repeat (2) @(negedge eph1);
    chk("reset_textout", 384'(enc_if.textout), '0);
    chk("reset_authdata", 384'(enc_if.authdata), '0);
    chk("reset_flags", 384'({enc_if.encdone, enc_if.sqzdone, enc_if.verify}), '0);
    reset = 1'b1;

    // Directed encrypt, then round trip and tampering on the decrypt instance.
    m_aead(K, N, AD, PT, 1'b0, ct, tag);
    issue(1'b0, K, N, AD, PT, 1'b0, '0, e0);
    wait_idle(1'b0, 200);
    chk("ct_differs_from_pt", 384'(enc_if.textout != PT), 384'(1));

    issue(1'b1, K, N, AD, ct, 1'b1, tag, e0);
    wait_idle(1'b1, 200);
    chk("roundtrip_pt", 384'(dec_if.textout), 384'(PT));
    chk("roundtrip_verify", 384'(dec_if.verify), 384'(1));

    issue(1'b1, K, N, AD, ct ^ 192'h1, 1'b1, tag, e0);
    wait_idle(1'b1, 200);
    chk("tamper_ct_text", 384'(dec_if.textout), 384'(PT ^ 192'h1));
    chk("tamper_ct_verify", 384'(dec_if.verify), 384'(0));

    issue(1'b1, K, N, AD, ct, 1'b1, tag ^ {1'b1, 127'h0}, e0);
    wait_idle(1'b1, 200);
    chk("tamper_tag_verify", 384'(dec_if.verify), 384'(0));

    // Start pulses while busy, including the edge sqzdone rises, must be ignored.
    issue(1'b0, K, N, AD, PT, 1'b0, tag, e0);
    repeat (4) @(negedge eph1);
    scramble(1'b0, 1'b1);
    @(negedge eph1);
    scramble(1'b0, 1'b0);
    while (cyc < e0 + 47) @(negedge eph1);
    scramble(1'b0, 1'b1);
    @(negedge eph1);
    scramble(1'b0, 1'b0);
    wait_idle(1'b0, 200);
    repeat (60) @(negedge eph1);

    // Back-to-back identical runs.
    issue(1'b0, K, N, AD, PT, 1'b0, tag, e0);
    wait_idle(1'b0, 200);
    issue(1'b0, K, N, AD, PT, 1'b0, tag, e0);
    wait_idle(1'b0, 200);

    // Reset mid-operation aborts with all outputs cleared and no done pulse.
    issue(1'b0, K, N, AD, PT, 1'b0, tag, e0);
    while (cyc < e0 + 20) @(negedge eph1);
    reset = 1'b0;
    #1;
    chk("midreset_textout", 384'(enc_if.textout), '0);
    chk("midreset_authdata", 384'(enc_if.authdata), '0);
    chk("midreset_flags", 384'({enc_if.encdone, enc_if.sqzdone, enc_if.verify}), '0);
    enc_q.delete();
    @(negedge eph1);
    reset = 1'b1;
    repeat (60) @(negedge eph1);
    chk("post_abort_textout", 384'(enc_if.textout), '0);
    issue(1'b0, K, N, AD, PT, 1'b0, '0, e0);
    wait_idle(1'b0, 200);

    // Randomized operations on either instance.
    for (int i = 0; i < 24; i++) begin
      d  = 1'($urandom);
      m  = 1'($urandom);
      vd = r128();
      if ($urandom_range(1, 0) == 1) begin
        m_aead(K ^ 128'(i), N, AD, PT, m, ct, tag);
        vd = tag;
        issue(d, K ^ 128'(i), N, AD, PT, m, vd, e0);
      end else begin
        issue(d, r128(), r128(), r128(), r192(), m, vd, e0);
      end
      wait_idle(d, 200);
    end

    repeat (5) @(negedge eph1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
